turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Game-flow controller for tic-tac-toe. Alternates turns between player X and player O and accepts one move per turn from the player whose turn it is.
- Validates each move against board occupancy, then issues a single-cycle board write.
- Samples the win detector after each write, counts moves to detect a draw, and enforces a per-turn time limit using a prescaled seconds countdown.
- Sits between the player input logic and the board register / win-detect datapath.

Parameters:
- TICK_DIV, 100000000, clock cycles per one-second tick; must be >= 2.
- TURN_SEC, 10, seconds allowed per turn; must be >= 1.
- N_CELLS, 9, number of board cells; legal positions are 0..N_CELLS-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begins a new game; honoured only in IDLE or DONE.
- req_x  in  1  move request from player X.
- pos_x  in  4  cell requested by X.
- req_o  in  1  move request from player O.
- pos_o  in  4  cell requested by O.
- occupied  in  N_CELLS  board occupancy from the board register; bit i set means cell i is taken.
- win  in  1  win detector output; valid in the cycle after wr_en.
- turn  out  1  current player: 0 = X, 1 = O.
- ack  out  1  one-cycle pulse: move accepted.
- nack  out  1  one-cycle pulse: move from the current player rejected.
- wr_en  out  1  one-cycle board write strobe.
- wr_pos  out  4  cell to write.
- wr_player  out  1  owner of the written cell.
- time_left  out  $clog2(TURN_SEC+1)  seconds remaining in the current turn.
- busy  out  1  game in progress (state TURN or CHECK).
- done  out  1  game finished; holds until the next start.
- winner  out  2  result: 00 = none, 01 = X, 10 = O, 11 = draw.
- timeout  out  1  set when the game ended by timer expiry.

Behaviour:
- Reset: rst=0 sampled on a clock edge forces state IDLE and clears every output and internal counter (turn=0, time_left=0, winner=00). Applies in any state, including mid-game.
- States: IDLE, TURN, CHECK, DONE.
- IDLE, start=1:
  - go to TURN with turn=0, move_cnt=0, prescaler=0, time_left=TURN_SEC;
  - clear winner and timeout.
- TURN: only the request of the current player (req_x when turn=0, req_o when turn=1) is examined. The other player's request is ignored: no nack.
  - Legal request (pos < N_CELLS and occupied[pos]=0): in the same edge, ack=1, wr_en=1, wr_pos=pos, wr_player=turn, move_cnt increments; go to CHECK.
  - Illegal request: nack=1 for one cycle; stay in TURN; timer is not reloaded.
- Timer:
  - prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted on the terminal count.
  - Each tick decrements time_left.
  - tick with time_left=1: time_left becomes 0; go to DONE with winner = the opponent, timeout=1.
  - A legal move in the same cycle as the expiring tick wins: the move is taken and there is no timeout.
- CHECK: exactly one cycle; samples win.
  - win=1: winner = current player; go to DONE.
  - Otherwise, move_cnt=N_CELLS: winner=11; go to DONE.
  - Otherwise: toggle turn, prescaler=0, time_left=TURN_SEC; go to TURN.
- DONE: done=1, busy=0; all results held.
  - start=1 restarts exactly as from IDLE.
  - start in TURN or CHECK is ignored.
- ack, nack and wr_en are never asserted together with each other outside the rules above; wr_en is never asserted outside TURN.

Optional Feature:
- MOVE_TIMEOUT_EN.
- Defined: timer behaviour as above.
- Undefined:
  - prescaler and countdown are not synthesised;
  - time_left is tied to 0 and timeout to 0;
  - TURN waits indefinitely for a legal move.

Decomposition:
- Package turn_sequencer_pkg holds:
  - the state enum (IDLE, TURN, CHECK, DONE);
  - player constants PLAYER_X=0, PLAYER_O=1;
  - result codes RES_NONE, RES_X, RES_O, RES_DRAW.
- Sub-module turn_timer:
  - contains the prescaler and seconds down-counter;
  - inputs: clk, rst, load, run;
  - outputs: time_left, expire;
  - instantiated only under MOVE_TIMEOUT_EN.

Test Plan (TICK_DIV=4, TURN_SEC=3 unless noted):
- Reset then start; X requests pos 4 with occupied=0 -> ack, wr_en, wr_pos=4, wr_player=0 on one edge; next cycle CHECK; with win=0, turn=1 and time_left=3.
- In X's turn, X requests pos 4 with occupied[4]=1 -> nack for one cycle, no wr_en. Then X requests pos 9 -> nack. O requests pos 0 during X's turn -> no response.
- No requests after start -> time_left goes 3, 2, 1, 0 at 4-cycle spacing; done=1, winner=10, timeout=1 twelve cycles after entering TURN.
- Legal move on the exact cycle of the expiring tick -> ack, no timeout, turn passes to O.
- Nine legal alternating moves with win=0 -> winner=11, done=1. Rerun with win=1 after X's fifth move -> winner=01.
- rst=0 mid-game (O's turn) -> next edge: IDLE, busy=0, turn=0, winner=00. start in DONE -> new game starts with X.

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package turn_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Result code naming the given player as the winner.
  function automatic logic [1:0] result_for(input logic player);
    return (player == PLAYER_O) ? RES_O : RES_X;
  endfunction

endpackage

// File: rtl/turn_sequencer_timer.sv
// Per-turn countdown: prescaler producing one-second ticks and a seconds
// down-counter. Only instantiated when MOVE_TIMEOUT_EN is defined.
module turn_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int TURN_SEC = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          run,
  output logic [$clog2(TURN_SEC+1)-1:0] time_left,
  output logic                          expire
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int TLW = $clog2(TURN_SEC + 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign expire = run && tick && (time_left == TLW'(1));

  // Prescaler wraps on its terminal count; each wrap takes one second off.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc     <= '0;
      time_left <= '0;
    end else if (load) begin
      presc     <= '0;
      time_left <= TLW'(TURN_SEC);
    end else if (run) begin
      if (tick) begin
        presc <= '0;
        if (time_left != '0) time_left <= time_left - TLW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe game-flow controller: alternates turns, validates moves against
// board occupancy, issues board writes, samples the win detector, detects a
// draw and (with MOVE_TIMEOUT_EN defined) enforces a per-turn time limit.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int TURN_SEC = 10,
  parameter int N_CELLS  = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          req_x,
  input  logic [3:0]                    pos_x,
  input  logic                          req_o,
  input  logic [3:0]                    pos_o,
  input  logic [N_CELLS-1:0]            occupied,
  input  logic                          win,
  output logic                          turn,
  output logic                          ack,
  output logic                          nack,
  output logic                          wr_en,
  output logic [3:0]                    wr_pos,
  output logic                          wr_player,
  output logic [$clog2(TURN_SEC+1)-1:0] time_left,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    winner,
  output logic                          timeout
);

  localparam int MCW = $clog2(N_CELLS + 1);

  if (TICK_DIV < 2 || TURN_SEC < 1 || N_CELLS < 1 || N_CELLS > 16) begin : g_param_check
    $error("turn_sequencer: parameter out of range");
  end

  state_t         state;
  logic [MCW-1:0] move_cnt;
  logic           cur_req;
  logic [3:0]     cur_pos;
  logic [15:0]    occ_ext;
  logic           legal;
  logic           expire;
  logic           last_move;

  assign cur_req   = (turn == PLAYER_X) ? req_x : req_o;
  assign cur_pos   = (turn == PLAYER_X) ? pos_x : pos_o;
  assign occ_ext   = 16'(occupied);
  assign legal     = cur_req && (32'(cur_pos) < N_CELLS) && !occ_ext[cur_pos];
  assign last_move = (move_cnt == MCW'(N_CELLS));

`ifdef MOVE_TIMEOUT_EN
  logic timer_load;
  logic timer_run;

  // A legal move holds the countdown so a move on the expiring tick wins.
  assign timer_load = ((state == IDLE || state == DONE) && start) ||
                      (state == CHECK && !win && !last_move);
  assign timer_run  = (state == TURN) && !legal;

  turn_timer #(
    .TICK_DIV (TICK_DIV),
    .TURN_SEC (TURN_SEC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .run       (timer_run),
    .time_left (time_left),
    .expire    (expire)
  );
`else
  assign time_left = '0;
  assign expire    = 1'b0;
`endif

  // Game state machine with registered outputs and single-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      move_cnt  <= '0;
      turn      <= PLAYER_X;
      ack       <= 1'b0;
      nack      <= 1'b0;
      wr_en     <= 1'b0;
      wr_pos    <= '0;
      wr_player <= PLAYER_X;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= RES_NONE;
      timeout   <= 1'b0;
    end else begin
      ack   <= 1'b0;
      nack  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= TURN;
            turn     <= PLAYER_X;
            move_cnt <= '0;
            winner   <= RES_NONE;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        TURN: begin
          if (legal) begin
            ack       <= 1'b1;
            wr_en     <= 1'b1;
            wr_pos    <= cur_pos;
            wr_player <= turn;
            move_cnt  <= move_cnt + MCW'(1);
            state     <= CHECK;
          end else begin
            if (cur_req) nack <= 1'b1;
            if (expire) begin
              state   <= DONE;
              winner  <= result_for(~turn);
              timeout <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (win) begin
            winner <= result_for(turn);
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (last_move) begin
            winner <= RES_DRAW;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            turn  <= ~turn;
            state <= TURN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer (TICK_DIV=4, TURN_SEC=3, N_CELLS=9).
module tb_turn_sequencer;

  localparam int TD = 4;
  localparam int TS = 3;
  localparam int NC = 9;
`ifdef MOVE_TIMEOUT_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, req_x, req_o, win;
  logic [3:0]    pos_x, pos_o;
  logic [NC-1:0] occupied;
  logic          turn, ack, nack, wr_en, wr_player, busy, done, timeout;
  logic [3:0]    wr_pos;
  logic [1:0]    time_left;
  logic [1:0]    winner;

  int checks = 0;
  int errors = 0;

  turn_sequencer #(.TICK_DIV(TD), .TURN_SEC(TS), .N_CELLS(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .req_x(req_x), .pos_x(pos_x),
    .req_o(req_o), .pos_o(pos_o), .occupied(occupied), .win(win),
    .turn(turn), .ack(ack), .nack(nack), .wr_en(wr_en), .wr_pos(wr_pos),
    .wr_player(wr_player), .time_left(time_left), .busy(busy), .done(done),
    .winner(winner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; req_x = 1'b0; req_o = 1'b0; pos_x = '0; pos_o = '0; win = 1'b0;
  endtask

  task automatic new_game();
    idle_inputs();
    occupied = '0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Seconds remaining after c countdown cycles spent in the current turn.
  function automatic logic [1:0] exp_tl(input int c);
    return TIMER_ON ? 2'(TS - c / TD) : 2'd0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    occupied = '0;
    rst = 1'b0;
    step(); step();
    checks++;
    if ({busy, done, turn, ack, nack, wr_en, wr_player, timeout} !== 8'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000000", {busy, done, turn, ack, nack, wr_en, wr_player, timeout});
    end
    checks++;
    if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b exp 00", winner); end
    checks++;
    if (time_left !== 2'd0) begin errors++; $display("FAIL reset_time_left got %0d exp 0", time_left); end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy got %b exp 0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, done, turn} !== 3'b100) begin errors++; $display("FAIL start_state got %b exp 100", {busy, done, turn}); end
    checks++;
    if (time_left !== exp_tl(0)) begin errors++; $display("FAIL start_time_left got %0d exp %0d", time_left, exp_tl(0)); end
  endtask

  task automatic test_first_move();
    new_game();
    req_x = 1'b1; pos_x = 4'd4;
    step();
    req_x = 1'b0;
    checks++;
    if ({ack, wr_en, nack} !== 3'b110) begin errors++; $display("FAIL move_strobes got %b exp 110", {ack, wr_en, nack}); end
    checks++;
    if ({wr_pos, wr_player} !== {4'd4, 1'b0}) begin errors++; $display("FAIL move_write got %0d/%b exp 4/0", wr_pos, wr_player); end
    win = 1'b0;
    step();
    checks++;
    if ({turn, ack, wr_en, busy, done} !== 5'b10010) begin errors++; $display("FAIL after_check got %b exp 10010", {turn, ack, wr_en, busy, done}); end
    checks++;
    if (time_left !== exp_tl(0)) begin errors++; $display("FAIL o_time_left got %0d exp %0d", time_left, exp_tl(0)); end
  endtask

  task automatic test_illegal();
    logic [3:0]    p;
    logic [NC-1:0] occ;
    logic [15:0]   occ16;
    logic          tm, legal;
    new_game();
    occupied = 9'b000010000;
    req_x = 1'b1; pos_x = 4'd4;
    step();
    req_x = 1'b0;
    checks++;
    if ({ack, nack, wr_en} !== 3'b010) begin errors++; $display("FAIL nack_occupied got %b exp 010", {ack, nack, wr_en}); end
    step();
    checks++;
    if (nack !== 1'b0) begin errors++; $display("FAIL nack_one_cycle got %b exp 0", nack); end
    occupied = '0;
    req_x = 1'b1; pos_x = 4'd9;
    step();
    req_x = 1'b0;
    checks++;
    if ({ack, nack, wr_en} !== 3'b010) begin errors++; $display("FAIL nack_range got %b exp 010", {ack, nack, wr_en}); end
    req_o = 1'b1; pos_o = 4'd0;
    step();
    req_o = 1'b0;
    checks++;
    if ({ack, nack, wr_en, turn} !== 4'b0000) begin errors++; $display("FAIL other_ignored got %b exp 0000", {ack, nack, wr_en, turn}); end
    // Random single requests against random occupancy.
    new_game();
    tm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = 4'($urandom_range(0, 15));
      occ = NC'($urandom);
      occ16 = 16'(occ);
      legal = (p < 4'(NC)) && !occ16[p];
      occupied = occ;
      if (tm) begin req_o = 1'b1; pos_o = p; req_x = 1'($urandom); pos_x = 4'($urandom); end
      else    begin req_x = 1'b1; pos_x = p; req_o = 1'($urandom); pos_o = 4'($urandom); end
      step();
      req_x = 1'b0; req_o = 1'b0;
      checks++;
      if ({ack, nack, wr_en} !== {legal, !legal, legal}) begin
        errors++; $display("FAIL rand_req pos %0d occ %b got %b exp %b", p, occ, {ack, nack, wr_en}, {legal, !legal, legal});
      end
      if (legal) begin
        step();
        tm = ~tm;
        checks++;
        if (turn !== tm) begin errors++; $display("FAIL rand_turn got %b exp %b", turn, tm); end
      end
    end
  endtask

  task automatic test_timeout();
    new_game();
    for (int c = 0; c < TS * TD; c++) begin
      checks++;
      if ({time_left, done} !== {exp_tl(c), 1'b0}) begin
        errors++; $display("FAIL countdown c=%0d got tl=%0d done=%b exp tl=%0d done=0", c, time_left, done, exp_tl(c));
      end
      start = (c == 5);
      step();
    end
    start = 1'b0;
    checks++;
    if ({done, timeout, busy} !== {TIMER_ON, TIMER_ON, !TIMER_ON}) begin
      errors++; $display("FAIL timeout_end got %b exp %b", {done, timeout, busy}, {TIMER_ON, TIMER_ON, !TIMER_ON});
    end
    checks++;
    if ({winner, time_left} !== {(TIMER_ON ? 2'b10 : 2'b00), 2'd0}) begin
      errors++; $display("FAIL timeout_result got %b/%0d exp %b/0", winner, time_left, TIMER_ON ? 2'b10 : 2'b00);
    end
  endtask

  task automatic test_expire_race();
    new_game();
    for (int c = 0; c < TS * TD - 1; c++) step();
    req_x = 1'b1; pos_x = 4'd2;
    step();
    req_x = 1'b0;
    checks++;
    if ({ack, wr_en, done, timeout} !== 4'b1100) begin errors++; $display("FAIL race_move got %b exp 1100", {ack, wr_en, done, timeout}); end
    step();
    checks++;
    if ({turn, done, time_left} !== {1'b1, 1'b0, exp_tl(0)}) begin
      errors++; $display("FAIL race_next got %b exp %b", {turn, done, time_left}, {1'b1, 1'b0, exp_tl(0)});
    end
  endtask

  // Plays moves to cells 0..8 in order from a fresh game; win pulses on move win_at.
  task automatic play_game(input int win_at, input logic [1:0] exp_w);
    for (int m = 0; m < NC; m++) begin
      occupied = NC'((1 << m) - 1);
      checks++;
      if (turn !== 1'(m % 2)) begin errors++; $display("FAIL seq_turn m=%0d got %b exp %0d", m, turn, m % 2); end
      if (m % 2 == 0) begin req_x = 1'b1; pos_x = 4'(m); end
      else            begin req_o = 1'b1; pos_o = 4'(m); end
      step();
      req_x = 1'b0; req_o = 1'b0;
      checks++;
      if ({ack, wr_pos, wr_player} !== {1'b1, 4'(m), 1'(m % 2)}) begin
        errors++; $display("FAIL seq_move m=%0d got %b exp %b", m, {ack, wr_pos, wr_player}, {1'b1, 4'(m), 1'(m % 2)});
      end
      win = (m == win_at);
      step();
      win = 1'b0;
      if (m == win_at) break;
    end
    checks++;
    if ({done, busy, winner, timeout} !== {2'b10, exp_w, 1'b0}) begin
      errors++; $display("FAIL seq_result got %b exp %b", {done, busy, winner, timeout}, {2'b10, exp_w, 1'b0});
    end
  endtask

  task automatic test_full_games();
    new_game(); play_game(-1, 2'b11);
    new_game(); play_game(8, 2'b01);
    new_game(); play_game(3, 2'b10);
  endtask

  task automatic test_reset_midgame();
    new_game();
    req_x = 1'b1; pos_x = 4'd0;
    step(); req_x = 1'b0; step();
    checks++;
    if (turn !== 1'b1) begin errors++; $display("FAIL mid_turn got %b exp 1", turn); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if ({busy, done, turn, winner, time_left} !== 7'b0) begin
      errors++; $display("FAIL mid_reset got %b exp 0000000", {busy, done, turn, winner, time_left});
    end
    start = 1'b1; step(); start = 1'b0;
    occupied = '0;
    play_game(-1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      req_x = 1'($urandom); pos_x = 4'($urandom); req_o = 1'($urandom); pos_o = 4'($urandom);
      step();
    end
    req_x = 1'b0; req_o = 1'b0;
    checks++;
    if ({done, winner, ack, nack, wr_en} !== 6'b111000) begin
      errors++; $display("FAIL done_hold got %b exp 111000", {done, winner, ack, nack, wr_en});
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({busy, done, turn, winner, timeout} !== 6'b100000) begin
      errors++; $display("FAIL restart got %b exp 100000", {busy, done, turn, winner, timeout});
    end
    checks++;
    if (time_left !== exp_tl(0)) begin errors++; $display("FAIL restart_tl got %0d exp %0d", time_left, exp_tl(0)); end
  endtask

  // Random games against a cell-list/turn-clock model of the rules.
  task automatic test_random_games();
    int         board[NC];
    int         moves, cyc, attempts, guard, s;
    bit         tm, over, stall, rq, legal, expire, found, w;
    logic [3:0] p;
    logic [1:0] final_w;
    for (int g = 0; g < 12; g++) begin
      new_game();
      foreach (board[i]) board[i] = 0;
      tm = 0; moves = 0; cyc = 0; over = 0; attempts = 0; guard = 0; final_w = 2'b00;
      stall = TIMER_ON && ($urandom_range(0, 5) == 0);
      while (!over && guard < 400) begin
        guard++;
        for (int i = 0; i < NC; i++) occupied[i] = (board[i] != 0);
        rq = stall ? 1'b0 : (attempts >= 6 || $urandom_range(0, 2) != 0);
        p = 4'($urandom_range(0, 15));
        if (!stall && (attempts >= 6 || $urandom_range(0, 1) == 1)) begin
          s = $urandom_range(0, NC - 1);
          found = 0;
          for (int k = 0; k < NC; k++)
            if (!found && board[(s + k) % NC] == 0) begin p = 4'((s + k) % NC); found = 1; end
        end
        legal = rq && (p < 4'(NC)) && (board[p] == 0);
        expire = TIMER_ON && !legal && (cyc == TS * TD - 1);
        if (tm) begin req_o = rq; pos_o = p; req_x = 1'($urandom); pos_x = 4'($urandom); end
        else    begin req_x = rq; pos_x = p; req_o = 1'($urandom); pos_o = 4'($urandom); end
        checks++;
        if ({turn, busy, done, time_left} !== {tm, 2'b10, exp_tl(cyc)}) begin
          errors++; $display("FAIL rg_pre g=%0d got %b exp %b", g, {turn, busy, done, time_left}, {tm, 2'b10, exp_tl(cyc)});
        end
        step();
        req_x = 1'b0; req_o = 1'b0;
        checks++;
        if ({ack, nack, wr_en} !== {legal, rq && !legal, legal}) begin
          errors++; $display("FAIL rg_strobe g=%0d pos %0d got %b exp %b", g, p, {ack, nack, wr_en}, {legal, rq && !legal, legal});
        end
        if (legal) begin
          checks++;
          if ({wr_pos, wr_player} !== {p, tm}) begin errors++; $display("FAIL rg_write got %b exp %b", {wr_pos, wr_player}, {p, tm}); end
          board[p] = tm ? 2 : 1;
          moves++;
          attempts = 0;
          w = ($urandom_range(0, 9) == 0);
          win = w;
          req_x = 1'($urandom); pos_x = 4'($urandom); req_o = 1'($urandom); pos_o = 4'($urandom);
          step();
          win = 1'b0; req_x = 1'b0; req_o = 1'b0;
          checks++;
          if ({ack, nack, wr_en} !== 3'b000) begin errors++; $display("FAIL rg_check_strobe got %b exp 000", {ack, nack, wr_en}); end
          if (w) begin final_w = tm ? 2'b10 : 2'b01; over = 1; end
          else if (moves == NC) begin final_w = 2'b11; over = 1; end
          else begin tm = ~tm; cyc = 0; stall = TIMER_ON && ($urandom_range(0, 7) == 0); end
          checks++;
          if ({done, busy, winner, timeout} !== {over, !over, final_w, 1'b0}) begin
            errors++; $display("FAIL rg_check g=%0d got %b exp %b", g, {done, busy, winner, timeout}, {over, !over, final_w, 1'b0});
          end
        end else if (expire) begin
          final_w = tm ? 2'b01 : 2'b10;
          over = 1;
          checks++;
          if ({done, busy, winner, timeout, time_left} !== {2'b10, final_w, 1'b1, 2'd0}) begin
            errors++; $display("FAIL rg_timeout g=%0d got %b exp %b", g, {done, busy, winner, timeout, time_left}, {2'b10, final_w, 1'b1, 2'd0});
          end
        end else begin
          attempts++;
          cyc++;
        end
      end
      checks++;
      if (over !== 1'b1) begin errors++; $display("FAIL rg_bound g=%0d got unfinished exp finished", g); end
      step(); step();
      checks++;
      if ({done, winner} !== {1'b1, final_w}) begin errors++; $display("FAIL rg_hold got %b exp %b", {done, winner}, {1'b1, final_w}); end
    end
  endtask

  initial begin
    rst = 1'b0;
    occupied = '0;
    idle_inputs();
    test_reset();
    test_first_move();
    test_illegal();
    test_timeout();
    test_expire_race();
    test_full_games();
    test_reset_midgame();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
